// File: rtl/cla_limb_sequencer_pkg.sv
// cla_seq_pkg: shared definitions for the multi-precision CLA limb sequencer.
//   LIMB_W   - width of one limb (matches the 16-bit CLA stage)
//   state_e  - sequencer FSM states
//   limb_lo  - bit offset of limb idx inside a wide operand
package cla_seq_pkg;

  localparam int LIMB_W = 16;

  // ISSUE is only used when the adder has zero latency.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int limb_lo(input int idx);
    return idx * LIMB_W;
  endfunction

endpackage

// File: rtl/cla_limb_sequencer.sv
// cla_limb_sequencer: multi-precision add/subtract controller wrapped around a
// registered 16-bit CLA stage. Wide operands are accepted over a valid/ready
// handshake and fed to the CLA one limb at a time, LSB first. Each limb's
// Cout is chained into the next limb's Cin, and the Sum limbs are assembled
// into a wide result that is held behind an output valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand request handshake (in_ready high only in IDLE)
//   in_a, in_b           wide operands (16*NUM_LIMBS bits)
//   in_sub, in_cin       0: A+B+cin   1: A-B-borrow (in_cin is the borrow)
//   add_a/add_b/add_cin  registered drive to the CLA stage
//   add_sum/add_cout     CLA stage results
//   out_valid/out_ready  result handshake
//   out_sum, out_cout    result; in sub mode out_cout=1 means no borrow
//   out_ovf              signed overflow (only with CLA_SEQ_OVF_EN defined)
//
// Build option: define CLA_SEQ_OVF_EN to add the out_ovf output.
import cla_seq_pkg::*;

module cla_limb_sequencer #(
  parameter int NUM_LIMBS = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LIMB_W*NUM_LIMBS-1:0]  in_a,
  input  logic [LIMB_W*NUM_LIMBS-1:0]  in_b,
  input  logic                         in_sub,
  input  logic                         in_cin,
  output logic [LIMB_W-1:0]            add_a,
  output logic [LIMB_W-1:0]            add_b,
  output logic                         add_cin,
  input  logic [LIMB_W-1:0]            add_sum,
  input  logic                         add_cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LIMB_W*NUM_LIMBS-1:0]  out_sum,
  output logic                         out_cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic                         out_ovf
`endif
);

  localparam int W       = LIMB_W * NUM_LIMBS;
  localparam int LIMB_IW = $clog2(NUM_LIMBS);
  localparam int CNT_W   = (ADDER_LAT < 1) ? 1 : $clog2(ADDER_LAT + 1);

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;        // already inverted in sub mode
  logic [W-1:0]         sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic [LIMB_IW-1:0]   limb_q, limb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LIMB_W-1:0]    add_a_q, add_a_d;
  logic [LIMB_W-1:0]    add_b_q, add_b_d;
  logic                 add_cin_q, add_cin_d;
  logic [W-1:0]         b_eff;
  int                   cur_lo, nxt_lo;
  logic                 last_limb;

`ifdef CLA_SEQ_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  // Subtraction is A + ~B + ~borrow, so B is inverted once at accept.
  assign b_eff     = in_sub ? ~in_b : in_b;
  assign cur_lo    = limb_lo(int'(limb_q));
  assign nxt_lo    = limb_lo(int'(limb_q) + 1);
  assign last_limb = (limb_q == LIMB_IW'(NUM_LIMBS - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    limb_d    = limb_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = b_eff;
          add_a_d   = in_a[LIMB_W-1:0];
          add_b_d   = b_eff[LIMB_W-1:0];
          add_cin_d = in_sub ^ in_cin;
          limb_d    = '0;
          cnt_d     = CNT_W'(ADDER_LAT);
          state_d   = (ADDER_LAT == 0) ? ISSUE : WAIT;
        end
      end
      ISSUE, WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // CLA output for the current limb is stable: capture it.
          sum_d[cur_lo +: LIMB_W] = add_sum;
          if (!last_limb) begin
            limb_d    = limb_q + 1'b1;
            add_a_d   = a_q[nxt_lo +: LIMB_W];
            add_b_d   = b_q[nxt_lo +: LIMB_W];
            add_cin_d = add_cout;
            cnt_d     = CNT_W'(ADDER_LAT);
          end else begin
            cout_d    = add_cout;
`ifdef CLA_SEQ_OVF_EN
            ovf_d     = (a_q[W-1] == b_q[W-1]) && (add_sum[LIMB_W-1] != a_q[W-1]);
`endif
            add_a_d   = '0;
            add_b_d   = '0;
            add_cin_d = 1'b0;
            limb_d    = '0;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      limb_q    <= '0;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      limb_q    <= limb_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
`ifdef CLA_SEQ_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule
